umi_mem_responder: RTL and testbench
====================================

# umi_mem_responder

Single-beat UMI memory endpoint that consumes requests from the output side of `umi_fifo` and returns responses on a UMI response channel. It holds a `DEPTH`-word internal memory and executes one read, write or posted write per accepted request. It gives the switchboard FIFO examples a self-checking device under test, using `umi_rx_sim` → `umi_fifo` → `umi_mem_responder` → `umi_tx_sim`.

## Interface

Parameters:

- `DW`, 256, data width in bits; power of two, ≥ 8
- `AW`, 64, address width
- `CW`, 32, command width; ≥ 8
- `DEPTH`, 16, memory words; power of two, ≥ 2

Ports (clock and reset first):

- `clk`  in  1  single clock; all logic on the rising edge
- `nreset`  in  1  reset, asynchronous and active-low
- `umi_in_valid`  in  1  request valid
- `umi_in_cmd`  in  CW  request command
- `umi_in_dstaddr`  in  AW  request target address
- `umi_in_srcaddr`  in  AW  requester return address
- `umi_in_data`  in  DW  write data
- `umi_in_ready`  out  1  request accepted when high together with valid
- `umi_out_valid`  out  1  response valid
- `umi_out_cmd`  out  CW  response command
- `umi_out_dstaddr`  out  AW  response destination
- `umi_out_srcaddr`  out  AW  response source
- `umi_out_data`  out  DW  read data
- `umi_out_ready`  in  1  response consumer ready
- `err_flag`  out  1  sticky; set by any unsupported request
- `req_count`  out  16  count of accepted requests, wraps

## Operation

- Opcode is `cmd[4:0]`:
  - REQ_READ = 0x01
  - REQ_WRITE = 0x03
  - REQ_POSTED = 0x05
  - RESP_READ = 0x02
  - RESP_WRITE = 0x04
- Word index: `idx = dstaddr[$clog2(DW/8) +: $clog2(DEPTH)]`. Other address bits and the size/len fields are ignored.
- Acceptance: a request is accepted when `umi_in_valid && umi_in_ready`.
  - `umi_in_ready = !out_slot_full || umi_out_ready`.
  - This is a one-entry output register with pass-through refill.
- REQ_READ:
  - Load the response register with `cmd = {in_cmd[CW-1:5], RESP_READ}`, `dstaddr = in_srcaddr`, `srcaddr = in_dstaddr`, `data = mem[idx]`.
- REQ_WRITE:
  - Write `mem[idx] <= in_data`.
  - Load the response register with `{in_cmd[CW-1:5], RESP_WRITE}`, swapped addresses, and `data = 0`.
- REQ_POSTED:
  - Write the memory; no response is generated.
  - The output slot may still drain in the same cycle.
- Any other opcode:
  - The request is accepted and dropped, and `err_flag <= 1`.
  - The memory is unchanged and no response is generated.
- `req_count` increments on every acceptance, including dropped requests, and wraps 0xFFFF → 0.
- Output slot state (FSM):
  - **EMPTY → FULL:** on acceptance of READ or WRITE.
  - **FULL → EMPTY:** on `umi_out_ready` with no new responding request.
  - **FULL → FULL:** on `umi_out_ready` with a responding request accepted in the same cycle; the register is reloaded.
  - **FULL, `!umi_out_ready`:** hold all `umi_out_*` stable and keep `umi_in_ready = 0`.

## Timing

- Reset values:
  - `umi_out_valid = 0`; `umi_out_cmd`, `umi_out_dstaddr`, `umi_out_srcaddr`, `umi_out_data` all 0.
  - `err_flag = 0`, `req_count = 0`, slot EMPTY.
- The memory contents are not reset.
- Latency: a response is valid on the cycle after acceptance (1 cycle).
- Throughput: one request per cycle while `umi_out_ready` is held high.
- Read-after-write: a write accepted in cycle N is visible to a read accepted in cycle N+1.
- Output stability: `umi_out_*` must not change while `umi_out_valid && !umi_out_ready`.
- `umi_in_ready` depends combinationally on `umi_out_ready` only; there is no path from `umi_in_valid` to `umi_in_ready`.
- Reset asserted mid-operation:
  - The pending response is discarded immediately (asynchronous reset); `umi_out_valid` falls in the same cycle.
  - No new request is accepted while `nreset = 0`.
  - Memory writes are suppressed while `nreset = 0`.

## Structure

- Package `umi_mem_pkg` holds the opcode localparams (`UMI_REQ_READ`, `UMI_REQ_WRITE`, `UMI_REQ_POSTED`, `UMI_RESP_READ`, `UMI_RESP_WRITE`) and a function `umi_opcode(cmd)`.
- Sub-module `umi_mem_ram`:
  - Single-port `DEPTH`×`DW` array, synchronous write.
  - Combinational read, captured into the response register.
- The top level contains the acceptance logic, the output-slot FSM, the error flag and the counter.

## Test plan

- **Write then read:** write 0xDEADBEEF to dstaddr 0x40, then read 0x40.
  - Responses are RESP_WRITE (data 0), then RESP_READ with data 0xDEADBEEF.
  - `dstaddr` equals the request `srcaddr` on both responses.
- **Back-to-back:** 16 writes to idx 0..15 with data = idx, then 16 reads, with `umi_out_ready` held at 1.
  - One response per cycle, data 0..15 in order.
  - `req_count` = 32.
- **Backpressure:** hold `umi_out_ready = 0` for 5 cycles with a read pending.
  - `umi_in_ready = 0` and `umi_out_*` stable throughout.
  - The response is delivered exactly once when ready rises.
- **Posted write:** posted write of 0x55 to idx 3, then read idx 3.
  - Exactly one response, RESP_READ with data 0x55.
- **Unsupported opcode:** opcode 0x1F.
  - No response, `err_flag = 1` and stays set, `req_count` increments.
- **Mid-operation reset:** assert reset with a response pending.
  - `umi_out_valid = 0` immediately; `req_count = 0`.
  - After release, a read of a previously written address returns the pre-reset data.

Source files
------------

// File: rtl/umi_mem_pkg.sv
// Shared opcode constants, opcode decode and slot state type for the UMI memory responder.
package umi_mem_pkg;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

    // Request class after decoding the opcode field
    typedef enum logic [1:0] {
        OpRead,
        OpWrite,
        OpPosted,
        OpBad
    } umi_op_e;

    // Output response register occupancy
    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } slot_state_e;

    // Opcode lives in cmd[4:0]; everything else in cmd is passed through untouched
    function automatic umi_op_e umi_opcode(input logic [4:0] cmd);
        umi_op_e op;
        unique case (cmd)
            UMI_REQ_READ:   op = OpRead;
            UMI_REQ_WRITE:  op = OpWrite;
            UMI_REQ_POSTED: op = OpPosted;
            default:        op = OpBad;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/umi_mem_ram.sv
// Single-port DEPTH x DW word array: synchronous write, combinational read.
module umi_mem_ram #(
    parameter int unsigned DW    = 256,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IdxW  = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic [DW-1:0]   rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset so they survive a reset pulse
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/umi_mem_responder.sv
// Single-beat UMI memory endpoint: executes read/write/posted requests against a small RAM and
// returns responses through a one-entry output register with pass-through refill.
module umi_mem_responder
    import umi_mem_pkg::*;
#(
    parameter int unsigned DW    = 256,
    parameter int unsigned AW    = 64,
    parameter int unsigned CW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    output logic [DW-1:0] umi_out_data,
    input  logic          umi_out_ready,
    output logic          err_flag,
    output logic [15:0]   req_count
);

    localparam int unsigned OffW = $clog2(DW / 8);
    localparam int unsigned IdxW = $clog2(DEPTH);

    slot_state_e   state_q, state_d;
    umi_op_e       op;
    logic          accept, responding, mem_we;
    logic [IdxW-1:0] idx;
    logic [DW-1:0] rdata;

    logic [CW-1:0] cmd_q, cmd_d;
    logic [AW-1:0] dst_q, dst_d, src_q, src_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;

    assign op         = umi_opcode(umi_in_cmd[4:0]);
    assign idx        = umi_in_dstaddr[OffW +: IdxW];
    assign accept     = umi_in_valid && umi_in_ready;
    assign responding = accept && (op == OpRead || op == OpWrite);
    assign mem_we     = accept && (op == OpWrite || op == OpPosted);

    umi_mem_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IdxW  (IdxW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (idx),
        .wdata_i (umi_in_data),
        .rdata_o (rdata)
    );

    // Slot state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: a responding request always (re)fills; otherwise drain on ready
    always_comb begin
        state_d = state_q;
        if (responding) begin
            state_d = StFull;
        end else if (umi_out_ready) begin
            state_d = StEmpty;
        end
    end

    // Slot outputs; ready is held low in reset so nothing is accepted or written then
    always_comb begin
        umi_out_valid = (state_q == StFull);
        umi_in_ready  = nreset && ((state_q == StEmpty) || umi_out_ready);
    end

    // Response payload, error flag and request counter next-state
    always_comb begin
        cmd_d  = cmd_q;
        dst_d  = dst_q;
        src_d  = src_q;
        data_d = data_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (responding) begin
            dst_d = umi_in_srcaddr;
            src_d = umi_in_dstaddr;
            if (op == OpRead) begin
                cmd_d  = {umi_in_cmd[CW-1:5], UMI_RESP_READ};
                data_d = rdata;
            end else begin
                cmd_d  = {umi_in_cmd[CW-1:5], UMI_RESP_WRITE};
                data_d = '0;
            end
        end
        if (accept && op == OpBad) begin
            err_d = 1'b1;
        end
    end

    // Response register, sticky error and counter state
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cmd_q  <= '0;
            dst_q  <= '0;
            src_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cmd_q  <= cmd_d;
            dst_q  <= dst_d;
            src_q  <= src_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign umi_out_cmd     = cmd_q;
    assign umi_out_dstaddr = dst_q;
    assign umi_out_srcaddr = src_q;
    assign umi_out_data    = data_q;
    assign err_flag        = err_q;
    assign req_count       = cnt_q;

endmodule

// File: tb/tb_umi_mem_responder.sv
// Scoreboard bench for umi_mem_responder: driver pushes expected responses, monitor pops/compares.
module tb_umi_mem_responder;

    localparam int DW    = 256;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int DEPTH = 16;

    localparam logic [CW-1:0] RD  = 32'h0000_0101;
    localparam logic [CW-1:0] WR  = 32'h0000_0103;
    localparam logic [CW-1:0] PW  = 32'h0000_0105;
    localparam logic [CW-1:0] BAD = 32'h0000_001F;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          umi_in_valid = 1'b0;
    logic [CW-1:0] umi_in_cmd = '0;
    logic [AW-1:0] umi_in_dstaddr = '0;
    logic [AW-1:0] umi_in_srcaddr = '0;
    logic [DW-1:0] umi_in_data = '0;
    logic          umi_in_ready;
    logic          umi_out_valid;
    logic [CW-1:0] umi_out_cmd;
    logic [AW-1:0] umi_out_dstaddr;
    logic [AW-1:0] umi_out_srcaddr;
    logic [DW-1:0] umi_out_data;
    logic          umi_out_ready = 1'b1;
    logic          err_flag;
    logic [15:0]   req_count;

    umi_mem_responder #(
        .DW    (DW),
        .AW    (AW),
        .CW    (CW),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .err_flag        (err_flag),
        .req_count       (req_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    tests   = 0;
    int    fails   = 0;
    int    exp_cnt = 0;
    int    stalls  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Monitor: compare every completed response handshake against the scoreboard head
    always @(negedge clk) begin
        resp_t e;
        #2;
        if (nreset && umi_out_valid && umi_out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got cmd %0h data %0h, want no response",
                         umi_out_cmd, umi_out_data);
            end else begin
                e = exp_q.pop_front();
                check("resp_cmd", DW'(umi_out_cmd), DW'(e.cmd));
                check("resp_dst", DW'(umi_out_dstaddr), DW'(e.dst));
                check("resp_src", DW'(umi_out_srcaddr), DW'(e.src));
                check("resp_data", umi_out_data, e.data);
            end
        end
    end

    // Issue one request (called at a negedge, returns at a negedge after acceptance)
    task automatic send(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                        input logic [AW-1:0] src, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata_exp);
        resp_t e;
        logic  r;
        r = 1'b0;
        umi_in_valid   = 1'b1;
        umi_in_cmd     = cmd;
        umi_in_dstaddr = dst;
        umi_in_srcaddr = src;
        umi_in_data    = wdata;
        e.dst = src;
        e.src = dst;
        if (cmd[4:0] == 5'h01) begin
            e.cmd  = {cmd[CW-1:5], 5'h02};
            e.data = rdata_exp;
            exp_q.push_back(e);
        end else if (cmd[4:0] == 5'h03) begin
            e.cmd  = {cmd[CW-1:5], 5'h04};
            e.data = '0;
            exp_q.push_back(e);
        end
        for (int k = 0; k <= 20; k++) begin
            #1 r = umi_in_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            stalls++;
        end
        if (r) begin
            exp_cnt++;
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got ready 0 for 21 cycles, want acceptance");
        end
        umi_in_valid = 1'b0;
    endtask

    // Let the scoreboard empty, bounded
    task automatic drain(input string name);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check(name, DW'(exp_q.size()), DW'(0));
    endtask

    function automatic logic [AW-1:0] addr(input int i);
        return AW'(i) << 5;
    endfunction

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", DW'(umi_out_valid), DW'(0));
        check("rst_out_cmd", DW'(umi_out_cmd), DW'(0));
        check("rst_out_dst", DW'(umi_out_dstaddr), DW'(0));
        check("rst_out_src", DW'(umi_out_srcaddr), DW'(0));
        check("rst_out_data", umi_out_data, DW'(0));
        check("rst_err", DW'(err_flag), DW'(0));
        check("rst_count", DW'(req_count), DW'(0));
        check("rst_in_ready", DW'(umi_in_ready), DW'(0));
        nreset = 1'b1;
        @(negedge clk);

        // Back-to-back: 16 writes then 16 reads (high address junk must be ignored)
        for (int i = 0; i < 16; i++) send(WR, addr(i), 64'h100 + AW'(i), DW'(i), '0);
        for (int i = 0; i < 16; i++)
            send(RD, addr(i) | 64'h8000_0000_0000_1000, 64'h200 + AW'(i), '0, DW'(i));
        drain("b2b_drain");
        check("b2b_count", DW'(req_count), DW'(32));
        check("b2b_no_stall", DW'(stalls), DW'(0));

        // Write then read at 0x40
        send(WR, 64'h40, 64'hAAA0, 256'hDEAD_BEEF, '0);
        send(RD, 64'h40, 64'hBBB0, '0, 256'hDEAD_BEEF);
        drain("wr_rd_drain");

        // Backpressure with a read pending
        umi_out_ready = 1'b0;
        send(RD, addr(5), 64'hC0, '0, DW'(5));
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready", DW'(umi_in_ready), DW'(0));
            check("bp_out_valid", DW'(umi_out_valid), DW'(1));
            check("bp_out_data", umi_out_data, DW'(5));
            check("bp_out_cmd", DW'(umi_out_cmd), DW'(32'h0000_0102));
            @(negedge clk);
        end
        umi_out_ready = 1'b1;
        drain("bp_drain");
        #1 check("bp_valid_after", DW'(umi_out_valid), DW'(0));
        @(negedge clk);

        // Posted write then read
        send(PW, addr(3), 64'h0, 256'h55, '0);
        send(RD, addr(3), 64'hD0, '0, 256'h55);
        drain("posted_drain");

        // Unsupported opcode: dropped, flagged, counted, memory untouched
        send(BAD, addr(3), 64'h0, 256'hFF, '0);
        @(negedge clk);
        check("bad_err", DW'(err_flag), DW'(1));
        check("bad_count", DW'(req_count), DW'(exp_cnt));
        send(RD, addr(3), 64'hD1, '0, 256'h55);
        drain("bad_drain");
        check("bad_err_sticky", DW'(err_flag), DW'(1));

        // Mid-operation reset with a read pending; a write attempted during reset is dropped
        send(WR, addr(7), 64'hE0, 256'hCAFE, '0);
        drain("pre_rst_drain");
        umi_out_ready = 1'b0;
        send(RD, addr(7), 64'hE1, '0, 256'hCAFE);
        nreset = 1'b0;
        #1;
        check("mrst_out_valid", DW'(umi_out_valid), DW'(0));
        check("mrst_count", DW'(req_count), DW'(0));
        check("mrst_err", DW'(err_flag), DW'(0));
        check("mrst_in_ready", DW'(umi_in_ready), DW'(0));
        exp_q.delete();
        exp_cnt = 0;
        umi_in_valid   = 1'b1;
        umi_in_cmd     = WR;
        umi_in_dstaddr = addr(7);
        umi_in_data    = 256'hBAD;
        repeat (2) @(negedge clk);
        umi_in_valid  = 1'b0;
        nreset        = 1'b1;
        umi_out_ready = 1'b1;
        @(negedge clk);
        send(RD, addr(7), 64'hE2, '0, 256'hCAFE);
        drain("post_rst_drain");
        check("post_rst_count", DW'(req_count), DW'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
